packet_assembler: RTL

PACKET_ASSEMBLER -- requirements
Module: packet_assembler

---
 rtl/packet_assembler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/packet_assembler.sv
// packet_assembler: reassembles NoC flits into packets using a pool
// of reassembly slots feeding a latched valid/ready output.
module packet_assembler #(
    parameter int NODE_ID         = 0,
    parameter int NODE_COUNT      = 8,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int PAYLOAD         = 32,
    parameter int FLIT_PAYLOAD    = 8,
    parameter int SLOT_COUNT      = 4,
    localparam int FLIT_COUNT =
        (PAYLOAD + FLIT_PAYLOAD - 1) / FLIT_PAYLOAD,
    localparam int NW = $clog2(NODE_COUNT),
    localparam int CW = (FLIT_COUNT > 1) ? $clog2(FLIT_COUNT) : 1,
    localparam int FLIT_WIDTH =
        1 + 2*NW + FLIT_PAYLOAD + PACKET_ID_WIDTH + CW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ce,
    input  logic [FLIT_WIDTH-1:0]      flit_in,
    input  logic                       flit_valid,
    output logic                       flit_ack,
    output logic [PAYLOAD-1:0]         packet_out,
    output logic [NW-1:0]              node_src,
    output logic [PACKET_ID_WIDTH-1:0] packet_id_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic                       misroute
);
    localparam int SW = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;
    localparam int DW = FLIT_COUNT * FLIT_PAYLOAD;
    localparam int IW = PACKET_ID_WIDTH;
    localparam int FP = FLIT_PAYLOAD;
    localparam logic [NW-1:0] MY_NODE = NW'(NODE_ID);

    logic [CW-1:0] f_idx;
    logic [NW-1:0] f_src;
    logic [IW-1:0] f_id;
    logic [FP-1:0] f_pay;
    logic [NW-1:0] f_dst;
    logic          f_mark;

    assign f_idx  = flit_in[CW-1:0];
    assign f_src  = flit_in[CW +: NW];
    assign f_id   = flit_in[CW+NW +: IW];
    assign f_pay  = flit_in[CW+NW+IW +: FP];
    assign f_dst  = flit_in[CW+NW+IW+FP +: NW];
    assign f_mark = flit_in[FLIT_WIDTH-1];

    logic [SLOT_COUNT-1:0]                 open_q, open_d;
    logic [SLOT_COUNT-1:0][NW-1:0]         src_q, src_d;
    logic [SLOT_COUNT-1:0][IW-1:0]         id_q, id_d;
    logic [SLOT_COUNT-1:0][FLIT_COUNT-1:0] mask_q, mask_d;
    logic [SLOT_COUNT-1:0][DW-1:0]         data_q, data_d;
    logic [SW-1:0]                         out_sel;
    logic                                  misroute_q;

    logic offered, bad, hit, free_any, dup, drop;
    logic take, wr, hs, arb_hit;
    logic [SW-1:0] hit_sel, free_sel, wr_sel, arb_sel;
    logic [FLIT_COUNT-1:0] idx_bit;

    // Flit classification and slot lookup
    always_comb begin
        offered = flit_valid & f_mark;
        bad     = (f_dst != MY_NODE) || (int'(f_idx) >= FLIT_COUNT);
        for (int i = 0; i < FLIT_COUNT; i++) begin
            idx_bit[i] = (int'(f_idx) == i);
        end
        hit      = 1'b0;
        hit_sel  = '0;
        free_any = 1'b0;
        free_sel = '0;
        for (int s = SLOT_COUNT - 1; s >= 0; s--) begin
            if (open_q[s] && !(&mask_q[s]) &&
                src_q[s] == f_src && id_q[s] == f_id) begin
                hit     = 1'b1;
                hit_sel = SW'(s);
            end
            if (!open_q[s]) begin
                free_any = 1'b1;
                free_sel = SW'(s);
            end
        end
        dup    = hit && |(mask_q[hit_sel] & idx_bit);
        drop   = bad | dup;
        take   = rst_n & ce & offered & (drop | hit | free_any);
        wr     = take & ~drop;
        wr_sel = hit ? hit_sel : free_sel;
        hs     = valid_out & ready_in & ce;
    end

    // Next slot state; the arbiter looks at it so a packet completed
    // this cycle can be presented right after the completing edge.
    always_comb begin
        open_d = open_q;
        src_d  = src_q;
        id_d   = id_q;
        mask_d = mask_q;
        data_d = data_q;
        if (hs) begin
            open_d[out_sel] = 1'b0;
            mask_d[out_sel] = '0;
        end
        if (wr) begin
            if (!hit) begin
                open_d[wr_sel] = 1'b1;
                src_d[wr_sel]  = f_src;
                id_d[wr_sel]   = f_id;
                mask_d[wr_sel] = '0;
            end
            mask_d[wr_sel] = mask_d[wr_sel] | idx_bit;
            for (int i = 0; i < FLIT_COUNT; i++) begin
                if (idx_bit[i]) begin
                    data_d[wr_sel][i*FP +: FP] = f_pay;
                end
            end
        end
        arb_hit = 1'b0;
        arb_sel = '0;
        for (int s = SLOT_COUNT - 1; s >= 0; s--) begin
            if (open_d[s] && (&mask_d[s])) begin
                arb_hit = 1'b1;
                arb_sel = SW'(s);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q        <= '0;
            src_q         <= '0;
            id_q          <= '0;
            mask_q        <= '0;
            data_q        <= '0;
            out_sel       <= '0;
            valid_out     <= 1'b0;
            packet_out    <= '0;
            node_src      <= '0;
            packet_id_out <= '0;
            misroute_q    <= 1'b0;
        end else begin
            misroute_q <= take & drop;
            if (ce) begin
                open_q <= open_d;
                src_q  <= src_d;
                id_q   <= id_d;
                mask_q <= mask_d;
                data_q <= data_d;
                if (hs) begin
                    valid_out <= 1'b0;
                end else if (!valid_out && arb_hit) begin
                    valid_out     <= 1'b1;
                    out_sel       <= arb_sel;
                    packet_out    <= data_d[arb_sel][PAYLOAD-1:0];
                    node_src      <= src_d[arb_sel];
                    packet_id_out <= id_d[arb_sel];
                end
            end
        end
    end

    assign flit_ack = take;
    assign misroute = misroute_q;

endmodule
